serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 27 ++
 rtl/serial_addsub.sv | 150 +++++++++++++++
 tb/tb_serial_addsub.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the serial adder-subtractor.
// Master side issues start with operands and watches busy/done/result.
// Slave side is the arithmetic engine itself.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;

   modport master (
      output start, sub, cin, x, y,
      input  busy, done, s, co, ovf
   );

   modport slave (
      input  start, sub, cin, x, y,
      output busy, done, s, co, ovf
   );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB digit first, carry registered between digits.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+WIDTH/DIGIT.
// No backpressure: start is ignored while busy; a start during the done cycle chains straight into a new run.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic          clk,
   input  logic          rst,
   serial_addsub_if.slave bus
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic             last;
   logic [CW-1:0]    cnt;
   int               base;

   // Latched operands; b_reg already holds ~y for subtract so the adder never sees the mode.
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;

   // Partial sum accumulates digit by digit; the visible result only changes at completion.
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] part_nxt;
   logic [WIDTH-1:0] s_reg;
   logic             co_reg;
   logic             ovf_reg;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] d_sum;
   logic [DIGIT:0]   c;

   assign last = (cnt == LAST);

   // State register; reset drops straight back to IDLE, aborting any run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control strobes; DONE can accept a new request for back-to-back operation.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // One digit of ripple addition, selected by the digit counter, merged into the partial sum.
   always_comb begin
      base  = int'(cnt) * DIGIT;
      a_dig = a_reg[base +: DIGIT];
      b_dig = b_reg[base +: DIGIT];
      c     = '0;
      d_sum = '0;
      c[0]  = carry;
      for (int i = 0; i < DIGIT; i++) begin
         d_sum[i] = a_dig[i] ^ b_dig[i] ^ c[i];
         c[i+1]   = (a_dig[i] & b_dig[i]) | (a_dig[i] & c[i]) | (b_dig[i] & c[i]);
      end
      part_nxt             = part;
      part_nxt[base +: DIGIT] = d_sum;
   end

   // Operand latch, digit sequencing and result capture on the final digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         part    <= '0;
         s_reg   <= '0;
         co_reg  <= 1'b0;
         ovf_reg <= 1'b0;
      end else if (load) begin
         a_reg <= bus.x;
         b_reg <= bus.sub ? ~bus.y : bus.y;
         carry <= bus.sub ? ~bus.cin : bus.cin;
         cnt   <= '0;
         part  <= '0;
      end else if (step) begin
         carry <= c[DIGIT];
         part  <= part_nxt;
         if (last) begin
            // Carry into the MSB is c[DIGIT-1] of the top digit; XOR with carry out gives signed overflow.
            s_reg   <= part_nxt;
            co_reg  <= c[DIGIT];
            ovf_reg <= c[DIGIT] ^ c[DIGIT-1];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.s    = s_reg;
   assign bus.co   = co_reg;
   assign bus.ovf  = ovf_reg;

   // Busy and done are mutually exclusive by construction of the state encoding.
   a_busy_done: assert property (@(posedge clk) disable iff (rst) !(bus.busy && bus.done));

   // The digit counter must stay within the operand during a run.
   a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= LAST);

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: five instances covering DIGIT = 1, 2, 4, WIDTH and a 16-bit variant.
// Directed cases plus randomized operations compared against an arithmetic reference model.
// Ends with a single TB_RESULT summary line.
module tb_serial_addsub;

   logic clk;
   logic rst;

   int W_TAB [5] = '{8, 8, 8, 16, 8};
   int D_TAB [5] = '{1, 2, 4, 1, 8};

   int n_checks;
   int n_fail;

   logic [15:0] last_s  [5];
   logic        last_co [5];
   logic        last_ov [5];

   serial_addsub_if #(.WIDTH(8))  if0 ();
   serial_addsub_if #(.WIDTH(8))  if1 ();
   serial_addsub_if #(.WIDTH(8))  if2 ();
   serial_addsub_if #(.WIDTH(16)) if3 ();
   serial_addsub_if #(.WIDTH(8))  if4 ();

   serial_addsub #(.WIDTH(8),  .DIGIT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   serial_addsub #(.WIDTH(8),  .DIGIT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   serial_addsub #(.WIDTH(8),  .DIGIT(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
   serial_addsub #(.WIDTH(16), .DIGIT(1)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
   serial_addsub #(.WIDTH(8),  .DIGIT(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int u, input logic st, input logic sb, input logic ci,
                        input logic [15:0] xv, input logic [15:0] yv);
      case (u)
         0: begin if0.start = st; if0.sub = sb; if0.cin = ci; if0.x = xv[7:0]; if0.y = yv[7:0]; end
         1: begin if1.start = st; if1.sub = sb; if1.cin = ci; if1.x = xv[7:0]; if1.y = yv[7:0]; end
         2: begin if2.start = st; if2.sub = sb; if2.cin = ci; if2.x = xv[7:0]; if2.y = yv[7:0]; end
         3: begin if3.start = st; if3.sub = sb; if3.cin = ci; if3.x = xv;      if3.y = yv;      end
         default: begin if4.start = st; if4.sub = sb; if4.cin = ci; if4.x = xv[7:0]; if4.y = yv[7:0]; end
      endcase
   endtask

   task automatic sample(input int u, output logic bsy, output logic dn, output logic [15:0] sv,
                         output logic cov, output logic ovv);
      case (u)
         0: begin bsy = if0.busy; dn = if0.done; sv = {8'h00, if0.s}; cov = if0.co; ovv = if0.ovf; end
         1: begin bsy = if1.busy; dn = if1.done; sv = {8'h00, if1.s}; cov = if1.co; ovv = if1.ovf; end
         2: begin bsy = if2.busy; dn = if2.done; sv = {8'h00, if2.s}; cov = if2.co; ovv = if2.ovf; end
         3: begin bsy = if3.busy; dn = if3.done; sv = if3.s;          cov = if3.co; ovv = if3.ovf; end
         default: begin bsy = if4.busy; dn = if4.done; sv = {8'h00, if4.s}; cov = if4.co; ovv = if4.ovf; end
      endcase
   endtask

   // Reference: plain integer arithmetic, unsigned for result/carry, signed range test for overflow.
   task automatic model(input int w, input logic sb, input logic ci, input logic [15:0] xv,
                        input logic [15:0] yv, output logic [15:0] es, output logic eco, output logic eov);
      int mask, ux, uy, r, sx, sy, sr, half;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      ux   = int'(xv) & mask;
      uy   = int'(yv) & mask;
      r    = sb ? (ux - uy - int'(ci)) : (ux + uy + int'(ci));
      es   = 16'(r & mask);
      eco  = sb ? (r >= 0) : (r > mask);
      sx   = (ux >= half) ? ux - (1 << w) : ux;
      sy   = (uy >= half) ? uy - (1 << w) : uy;
      sr   = sb ? (sx - sy - int'(ci)) : (sx + sy + int'(ci));
      eov  = (sr < -half) || (sr > half - 1);
   endtask

   // Runs one operation to its done cycle; returns at the negedge where done is observed.
   task automatic run_op(input int u, input logic sb, input logic ci, input logic [15:0] xv,
                         input logic [15:0] yv, input bit poke, input bit chained);
      int          n;
      int          cyc;
      bit          got_done;
      logic        st;
      logic [15:0] es;
      logic        eco, eov;
      logic        bsy, dn, co_o, ov_o;
      logic [15:0] so;
      string       tg;
      n = W_TAB[u] / D_TAB[u];
      model(W_TAB[u], sb, ci, xv, yv, es, eco, eov);
      tg = $sformatf("u%0d %0h%s%0h c%0d", u, xv, sb ? "-" : "+", yv, ci);
      if (!chained) begin
         @(negedge clk);
         drive(u, 1'b1, sb, ci, xv, yv);
      end
      cyc      = 0;
      got_done = 0;
      for (int t = 0; t < n + 4 && !got_done; t++) begin
         @(negedge clk);
         st = (poke && n >= 3 && t == 1);
         drive(u, st, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         sample(u, bsy, dn, so, co_o, ov_o);
         if (dn) begin
            got_done = 1;
            chk({tg, " latency"}, 32'(cyc), 32'(n));
            chk({tg, " busy@done"}, 32'(bsy), 32'(0));
            chk({tg, " s"}, 32'(so), 32'(es));
            chk({tg, " co"}, 32'(co_o), 32'(eco));
            chk({tg, " ovf"}, 32'(ov_o), 32'(eov));
         end else begin
            cyc++;
            chk({tg, " busy"}, 32'(bsy), 32'(1));
            chk({tg, " s hold"}, 32'(so), 32'(last_s[u]));
         end
      end
      if (!got_done) chk({tg, " timeout"}, 32'(0), 32'(1));
      last_s[u]  = es;
      last_co[u] = eco;
      last_ov[u] = eov;
   endtask

   // One cycle after done: pulse over, block idle, result still held.
   task automatic idle_chk(input int u);
      logic        bsy, dn, co_o, ov_o;
      logic [15:0] so;
      @(negedge clk);
      drive(u, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      sample(u, bsy, dn, so, co_o, ov_o);
      chk($sformatf("u%0d done pulse", u), 32'(dn), 32'(0));
      chk($sformatf("u%0d idle busy", u), 32'(bsy), 32'(0));
      chk($sformatf("u%0d s held", u), 32'(so), 32'(last_s[u]));
      chk($sformatf("u%0d co held", u), 32'(co_o), 32'(last_co[u]));
   endtask

   task automatic clear_model;
      for (int u = 0; u < 5; u++) begin
         last_s[u]  = '0;
         last_co[u] = 1'b0;
         last_ov[u] = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      logic        bsy, dn, co_o, ov_o;
      logic [15:0] so;
      int          busy_seen;
      int          done_seen;
      bit          pend;
      logic        sb, ci;
      logic [15:0] xv, yv;

      n_checks = 0;
      n_fail   = 0;
      clear_model();
      rst = 1'b1;
      for (int u = 0; u < 5; u++) drive(u, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);

      // Reset state of every instance.
      for (int u = 0; u < 5; u++) begin
         sample(u, bsy, dn, so, co_o, ov_o);
         chk($sformatf("u%0d rst busy", u), 32'(bsy), 32'(0));
         chk($sformatf("u%0d rst done", u), 32'(dn), 32'(0));
         chk($sformatf("u%0d rst s", u), 32'(so), 32'(0));
         chk($sformatf("u%0d rst co", u), 32'(co_o), 32'(0));
         chk($sformatf("u%0d rst ovf", u), 32'(ov_o), 32'(0));
      end
      rst = 1'b0;

      // Directed cases.
      run_op(0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 0, 0); idle_chk(0);
      chk("dir FF+01 s", 32'(last_s[0]), 32'h00);
      chk("dir FF+01 co", 32'(last_co[0]), 32'h1);
      run_op(1, 1'b0, 1'b0, 16'h007F, 16'h0001, 0, 0); idle_chk(1);
      run_op(2, 1'b1, 1'b0, 16'h0005, 16'h0007, 0, 0); idle_chk(2);
      run_op(2, 1'b1, 1'b0, 16'h0080, 16'h0001, 0, 0); idle_chk(2);
      run_op(0, 1'b0, 1'b1, 16'h0012, 16'h0034, 1, 0); idle_chk(0);
      run_op(4, 1'b0, 1'b1, 16'h00C3, 16'h0041, 0, 0); idle_chk(4);
      // Back-to-back: start asserted in the done cycle.
      run_op(1, 1'b1, 1'b1, 16'h0010, 16'h0020, 0, 0);
      drive(1, 1'b1, 1'b0, 1'b1, 16'h00A5, 16'h005A);
      run_op(1, 1'b0, 1'b1, 16'h00A5, 16'h005A, 0, 1); idle_chk(1);

      // Reset in the third RUN cycle of the 16-bit instance.
      run_op(3, 1'b0, 1'b0, 16'h1234, 16'hF00D, 0, 0); idle_chk(3);
      @(negedge clk);
      drive(3, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0101);
      busy_seen = 0;
      for (int t = 0; t < 10 && busy_seen < 3; t++) begin
         @(negedge clk);
         drive(3, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0101);
         sample(3, bsy, dn, so, co_o, ov_o);
         if (bsy) busy_seen++;
      end
      chk("rst run cycles", 32'(busy_seen), 32'(3));
      #2 rst = 1'b1;
      #1;
      sample(3, bsy, dn, so, co_o, ov_o);
      chk("rst mid busy", 32'(bsy), 32'(0));
      chk("rst mid done", 32'(dn), 32'(0));
      chk("rst mid s", 32'(so), 32'(0));
      chk("rst mid co", 32'(co_o), 32'(0));
      chk("rst mid ovf", 32'(ov_o), 32'(0));
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         sample(3, bsy, dn, so, co_o, ov_o);
         if (dn || bsy) done_seen++;
      end
      chk("rst no done", 32'(done_seen), 32'(0));
      run_op(3, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0, 0); idle_chk(3);
      chk("post rst s", 32'(last_s[3]), 32'h0);
      chk("post rst co", 32'(last_co[3]), 32'h1);

      // Randomized operations, with random mid-run pokes and chained starts.
      for (int u = 0; u < 5; u++) begin
         pend = 0;
         for (int i = 0; i < 12; i++) begin
            sb = 1'($urandom);
            ci = 1'($urandom);
            xv = 16'($urandom);
            yv = 16'($urandom);
            if (pend && $urandom_range(0, 2) == 0) begin
               drive(u, 1'b1, sb, ci, xv, yv);
               run_op(u, sb, ci, xv, yv, $urandom_range(0, 3) == 0, 1);
            end else begin
               if (pend) idle_chk(u);
               run_op(u, sb, ci, xv, yv, $urandom_range(0, 3) == 0, 0);
            end
            pend = 1;
         end
         idle_chk(u);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
